// File: rtl/regfile_wb.sv
// ----------------------------------------------------------------------------
// regfile_wb
//
// General-purpose register file and write-back endpoint for the five-stage
// pipeline. It commits the execute-path write-back triple into a
// REG_NUM x DATA_W register array. It serves two combinational decode-stage
// operand reads. It also keeps a per-register pending scoreboard, so decode
// can tell which operands have an issued producer that has not yet written
// back.
//
// Optional feature (compile-time macro):
//   REGFILE_BYPASS_EN - forward wdata_i to a read port whose address matches
//                       the write-back address in the same cycle. The same
//                       hit also masks that port's pending flag.
//
// Ports:
//   clk          single clock, all state updates on the rising edge
//   rst          asynchronous active-low reset (0 = reset asserted)
//   we_i         write-back enable
//   waddr_i      write-back register address
//   wdata_i      write-back data
//   re1_i        read port 1 enable
//   raddr1_i     read port 1 address
//   rdata1_o     read port 1 data
//   pend1_o      read port 1 operand not yet available
//   re2_i, raddr2_i, rdata2_o, pend2_o : read port 2, same as port 1
//   pset_i       mark a destination pending (issued producer)
//   paddr_i      destination register to mark
//   any_pend_o   at least one register pending (registered view)
// ----------------------------------------------------------------------------
module regfile_wb #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int REG_NUM = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re1_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic              pend1_o,
    input  logic              re2_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    output logic [DATA_W-1:0] rdata2_o,
    output logic              pend2_o,
    input  logic              pset_i,
    input  logic [ADDR_W-1:0] paddr_i,
    output logic              any_pend_o
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]  regs_q [REG_NUM];
    logic [DATA_W-1:0]  regs_d [REG_NUM];
    logic [REG_NUM-1:0] pend_q;
    logic [REG_NUM-1:0] pend_d;

    logic wr_en;
    logic set_en;

    // r0 is hard-wired, so a write or pending-mark aimed at it is a no-op.
    assign wr_en  = we_i   && (waddr_i != '0);
    assign set_en = pset_i && (paddr_i != '0);

    // ------------------------------------------------------------------
    // Next-state: array write and scoreboard update
    // ------------------------------------------------------------------
    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        if (wr_en) begin
            regs_d[waddr_i] = wdata_i;
            pend_d[waddr_i] = 1'b0;
        end
        // Apply the set after the clear. On a same-address race, the newly
        // issued producer keeps the register pending.
        if (set_en) begin
            pend_d[paddr_i] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    // ------------------------------------------------------------------
    // Registers. Reset clears the whole array asynchronously, so storage
    // is flop based rather than RAM based.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < REG_NUM; gi++) begin : g_reg
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    regs_q[gi] <= '0;
                end else begin
                    regs_q[gi] <= regs_d[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // ------------------------------------------------------------------
    // Read ports. Both ports share one implementation, indexed by gi.
    // ------------------------------------------------------------------
    logic              re_v    [2];
    logic [ADDR_W-1:0] raddr_v [2];

    assign re_v[0]    = re1_i;
    assign re_v[1]    = re2_i;
    assign raddr_v[0] = raddr1_i;
    assign raddr_v[1] = raddr2_i;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            logic              hit;
            logic [DATA_W-1:0] rdata_g;
            logic              pend_g;

`ifdef REGFILE_BYPASS_EN
            assign hit = wr_en && re_v[gi] && (raddr_v[gi] == waddr_i);
`else
            assign hit = 1'b0;
`endif

            always_comb begin
                rdata_g = '0;
                pend_g  = 1'b0;
                // Outputs read as zero while reset is asserted, when the
                // port is disabled, or when the port addresses r0.
                if (rst && re_v[gi] && (raddr_v[gi] != '0)) begin
                    if (hit) begin
                        rdata_g = wdata_i;
                    end else begin
                        rdata_g = regs_q[raddr_v[gi]];
                    end
                    // A forwarded operand is available now, even though its
                    // pending bit clears only at the coming edge.
                    pend_g = pend_q[raddr_v[gi]] && !hit;
                end
            end
        end
    endgenerate

    assign rdata1_o = g_rd[0].rdata_g;
    assign pend1_o  = g_rd[0].pend_g;
    assign rdata2_o = g_rd[1].rdata_g;
    assign pend2_o  = g_rd[1].pend_g;

    // Registered view of the scoreboard. pend_q is already zero while reset
    // is asserted.
    assign any_pend_o = |pend_q;

endmodule

// File: tb/tb_regfile_wb.sv
module tb_regfile_wb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we_i = 1'b0;
    logic [4:0]  waddr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        re1_i = 1'b0;
    logic [4:0]  raddr1_i = '0;
    logic [31:0] rdata1_o;
    logic        pend1_o;
    logic        re2_i = 1'b0;
    logic [4:0]  raddr2_i = '0;
    logic [31:0] rdata2_o;
    logic        pend2_o;
    logic        pset_i = 1'b0;
    logic [4:0]  paddr_i = '0;
    logic        any_pend_o;

    int checks = 0;
    int passed = 0;

    // Reference model: architectural register contents and pending set.
    logic [31:0] mem_m [32];
    logic [31:0] pend_m;

    regfile_wb dut (
        .clk(clk), .rst(rst),
        .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
        .re1_i(re1_i), .raddr1_i(raddr1_i), .rdata1_o(rdata1_o), .pend1_o(pend1_o),
        .re2_i(re2_i), .raddr2_i(raddr2_i), .rdata2_o(rdata2_o), .pend2_o(pend2_o),
        .pset_i(pset_i), .paddr_i(paddr_i), .any_pend_o(any_pend_o)
    );

    always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    function automatic void model_clear();
        for (int i = 0; i < 32; i++) mem_m[i] = '0;
        pend_m = '0;
    endfunction

    function automatic logic bypass_hit(input logic re, input logic [4:0] ra);
        return BYP && we_i && re && (ra == waddr_i) && (waddr_i != 0);
    endfunction

    function automatic logic [31:0] exp_rdata(input logic re, input logic [4:0] ra);
        if (!rst || !re || ra == 0) return 32'h0;
        if (bypass_hit(re, ra)) return wdata_i;
        return mem_m[ra];
    endfunction

    function automatic logic exp_pend(input logic re, input logic [4:0] ra);
        if (!rst || !re || ra == 0) return 1'b0;
        if (bypass_hit(re, ra)) return 1'b0;
        return pend_m[ra];
    endfunction

    // Commit current inputs to the model, then advance one clock edge.
    task automatic step();
        if (!rst) begin
            model_clear();
        end else begin
            if (we_i && waddr_i != 0) begin
                mem_m[waddr_i] = wdata_i;
                pend_m[waddr_i] = 1'b0;
            end
            if (pset_i && paddr_i != 0) pend_m[paddr_i] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we_i = 0; waddr_i = 0; wdata_i = 0; pset_i = 0; paddr_i = 0;
        re1_i = 0; raddr1_i = 0; re2_i = 0; raddr2_i = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        model_clear();
        for (int c = 0; c < 4; c++) begin
            we_i = 1'b1; waddr_i = 5'($urandom); wdata_i = $urandom;
            re1_i = 1'b1; raddr1_i = waddr_i; re2_i = 1'b1; raddr2_i = 5'($urandom);
            pset_i = 1'b1; paddr_i = 5'($urandom);
            #1;
            checks++;
            if ({rdata1_o, rdata2_o, pend1_o, pend2_o, any_pend_o} !== 67'h0)
                $display("FAIL reset_outputs cycle %0d: got r1=%h r2=%h p1=%b p2=%b any=%b want all 0",
                         c, rdata1_o, rdata2_o, pend1_o, pend2_o, any_pend_o);
            else passed++;
            step();
        end
        idle();
        rst = 1;
        step();
        for (int r = 1; r < 32; r++) begin
            re1_i = 1; raddr1_i = 5'(r); re2_i = 1; raddr2_i = 5'(r);
            #1;
            checks++;
            if (rdata1_o !== 32'h0 || rdata2_o !== 32'h0)
                $display("FAIL reset_array r%0d: got %h/%h want 0", r, rdata1_o, rdata2_o);
            else passed++;
            step();
        end
        idle();
    endtask

    task automatic test_write_read();
        we_i = 1; waddr_i = 5; wdata_i = 32'h1234_5678;
        step();
        idle();
        re1_i = 1; raddr1_i = 5; re2_i = 1; raddr2_i = 0;
        #1;
        checks++;
        if (rdata1_o !== 32'h1234_5678 || rdata2_o !== 32'h0)
            $display("FAIL write_read r5/r0: got %h/%h want 12345678/00000000", rdata1_o, rdata2_o);
        else passed++;
        step();
        idle();
        we_i = 1; waddr_i = 0; wdata_i = 32'hFFFF_FFFF;
        step();
        idle();
        re1_i = 1; raddr1_i = 0;
        #1;
        checks++;
        if (rdata1_o !== 32'h0)
            $display("FAIL write_r0: got %h want 0", rdata1_o);
        else passed++;
        step();
        idle();
    endtask

    task automatic test_collision();
        we_i = 1; waddr_i = 7; wdata_i = 32'hA5A5_A5A5;
        re2_i = 1; raddr2_i = 7;
        #1;
        checks++;
        if (rdata2_o !== (BYP ? 32'hA5A5_A5A5 : 32'h0))
            $display("FAIL collision_same_cycle: got %h want %h", rdata2_o, BYP ? 32'hA5A5_A5A5 : 32'h0);
        else passed++;
        step();
        we_i = 0;
        #1;
        checks++;
        if (rdata2_o !== 32'hA5A5_A5A5)
            $display("FAIL collision_next_cycle: got %h want a5a5a5a5", rdata2_o);
        else passed++;
        step();
        idle();
    endtask

    task automatic test_scoreboard();
        pset_i = 1; paddr_i = 9;
        re1_i = 1; raddr1_i = 9;
        #1;
        checks++;
        if (pend1_o !== 1'b0)
            $display("FAIL sb_cycle0: got pend1=%b want 0", pend1_o);
        else passed++;
        step();
        pset_i = 0;
        #1;
        checks++;
        if (pend1_o !== 1'b1 || any_pend_o !== 1'b1)
            $display("FAIL sb_cycle1: got pend1=%b any=%b want 1/1", pend1_o, any_pend_o);
        else passed++;
        step();
        step();
        we_i = 1; waddr_i = 9; wdata_i = 32'h0000_0909;
        #1;
        checks++;
        if (pend1_o !== (BYP ? 1'b0 : 1'b1) || any_pend_o !== 1'b1)
            $display("FAIL sb_cycle3: got pend1=%b any=%b want %b/1", pend1_o, any_pend_o, !BYP);
        else passed++;
        step();
        we_i = 0;
        #1;
        checks++;
        if (pend1_o !== 1'b0 || any_pend_o !== 1'b0 || rdata1_o !== 32'h0000_0909)
            $display("FAIL sb_cycle4: got pend1=%b any=%b data=%h want 0/0/00000909",
                     pend1_o, any_pend_o, rdata1_o);
        else passed++;
        step();
        idle();
    endtask

    task automatic test_race();
        pset_i = 1; paddr_i = 9;
        step();
        we_i = 1; waddr_i = 9; wdata_i = 32'hCAFE_0009;
        step();
        idle();
        re1_i = 1; raddr1_i = 9;
        #1;
        checks++;
        if (pend1_o !== 1'b1 || rdata1_o !== 32'hCAFE_0009 || any_pend_o !== 1'b1)
            $display("FAIL set_clear_race: got pend1=%b data=%h any=%b want 1/cafe0009/1",
                     pend1_o, rdata1_o, any_pend_o);
        else passed++;
        we_i = 1; waddr_i = 9;
        step();
        idle();
    endtask

    task automatic test_async_reset();
        we_i = 1; waddr_i = 3; wdata_i = 32'h55;
        step();
        idle();
        pset_i = 1; paddr_i = 3;
        step();
        idle();
        re1_i = 1; raddr1_i = 3; re2_i = 1; raddr2_i = 3;
        #1;
        checks++;
        if (pend1_o !== 1'b1 || rdata1_o !== 32'h55)
            $display("FAIL async_pre: got pend1=%b data=%h want 1/00000055", pend1_o, rdata1_o);
        else passed++;
        we_i = 1; waddr_i = 3; wdata_i = 32'hAA;
        #1;
        rst = 0;
        model_clear();
        #1;
        checks++;
        if ({rdata1_o, rdata2_o, pend1_o, pend2_o, any_pend_o} !== 67'h0)
            $display("FAIL async_during: got r1=%h r2=%h p1=%b p2=%b any=%b want all 0",
                     rdata1_o, rdata2_o, pend1_o, pend2_o, any_pend_o);
        else passed++;
        we_i = 0;
        #1;
        rst = 1;
        #1;
        checks++;
        if (rdata1_o !== 32'h0 || pend1_o !== 1'b0 || any_pend_o !== 1'b0)
            $display("FAIL async_after: got data=%h pend1=%b any=%b want 0/0/0",
                     rdata1_o, pend1_o, any_pend_o);
        else passed++;
        step();
        idle();
    endtask

    task automatic test_random();
        logic [31:0] e1, e2;
        logic        p1, p2, ap;
        for (int c = 0; c < 400; c++) begin
            we_i = ($urandom_range(0, 2) != 0); waddr_i = 5'($urandom_range(0, 7));
            wdata_i = $urandom;
            pset_i = ($urandom_range(0, 2) == 0); paddr_i = 5'($urandom_range(0, 7));
            re1_i = ($urandom_range(0, 3) != 0); raddr1_i = 5'($urandom_range(0, 7));
            re2_i = ($urandom_range(0, 3) != 0); raddr2_i = 5'($urandom_range(0, 7));
            #1;
            e1 = exp_rdata(re1_i, raddr1_i); e2 = exp_rdata(re2_i, raddr2_i);
            p1 = exp_pend(re1_i, raddr1_i);  p2 = exp_pend(re2_i, raddr2_i);
            ap = (pend_m != 0);
            checks++;
            if (rdata1_o !== e1 || rdata2_o !== e2 || pend1_o !== p1 || pend2_o !== p2 || any_pend_o !== ap)
                $display("FAIL random cycle %0d: got r1=%h r2=%h p1=%b p2=%b any=%b want %h %h %b %b %b",
                         c, rdata1_o, rdata2_o, pend1_o, pend2_o, any_pend_o, e1, e2, p1, p2, ap);
            else passed++;
            step();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_collision();
        test_scoreboard();
        test_race();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb.md
# regfile_wb

General-purpose register file and write-back endpoint for the five-stage pipeline. It receives the `waddr/we/wdata` triple produced by the execute path, commits it to a 32-entry register array, and serves the two decode-stage operand reads. A per-register pending scoreboard lets decode detect operands whose producer has issued but not yet written back.

## Interface
Parameters:
- `DATA_W`, 32, register width.
- `ADDR_W`, 5, register address width.
- `REG_NUM`, 32, number of registers; must equal 2^`ADDR_W`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low (0 = reset asserted).
- `we_i`  in  1  write-back enable.
- `waddr_i`  in  ADDR_W  write-back register address.
- `wdata_i`  in  DATA_W  write-back data.
- `re1_i`  in  1  read port 1 enable.
- `raddr1_i`  in  ADDR_W  read port 1 address.
- `rdata1_o`  out  DATA_W  read port 1 data.
- `pend1_o`  out  1  read port 1 operand not yet available.
- `re2_i`, `raddr2_i`, `rdata2_o`, `pend2_o`: read port 2, identical to port 1.
- `pset_i`  in  1  mark a destination pending (issued producer).
- `paddr_i`  in  ADDR_W  destination to mark.
- `any_pend_o`  out  1  at least one register pending.

## Operation
- Storage: `REG_NUM` × `DATA_W` array. r0 reads 0 always. Writes to r0 are ignored. r0 never becomes pending.
- Write: on a rising edge with `we_i`=1 and `waddr_i`≠0, `array[waddr_i]` ← `wdata_i`.
- Read (combinational), per port n, in priority order:
  - `rst`=0 → 0.
  - `re_n`=0 → 0.
  - `raddr_n`=0 → 0.
  - Bypass hit → `wdata_i` (see Configuration).
  - Otherwise → `array[raddr_n]`.
- Scoreboard: `pend[REG_NUM]` bit vector, r0 bit fixed at 0.
  - Rising edge with `pset_i`=1 and `paddr_i`≠0 sets `pend[paddr_i]`.
  - Rising edge with `we_i`=1 and `waddr_i`≠0 clears `pend[waddr_i]`.
  - Set and clear of the same address on the same edge: set wins (a new producer is in flight).
  - Set and clear of different addresses on the same edge: both take effect.
- `pend_n_o` = `re_n` & `pend[raddr_n]` & ~bypass-hit. Forced to 0 during reset and for r0.
- `any_pend_o` = OR of `pend`, registered view (no same-cycle clear lookahead).
- A write to a non-pending register is legal and updates data; the scoreboard is unchanged.

## Timing
- Reset asserted: array cleared to 0 and `pend` cleared, asynchronously. `rdata1_o`, `rdata2_o`, `pend1_o`, `pend2_o` and `any_pend_o` are all 0.
- Reset release: first state update on the first rising edge with `rst`=1.
- Reset asserted mid-operation: the in-flight write is discarded and all pending bits are lost.
- Write latency: the array is updated at the edge ending the cycle in which `we_i` is asserted.
  - With bypass, the data is visible on read ports in that same cycle.
  - Without bypass, the data is visible from the next cycle.
- Scoreboard latency: `pset_i` in cycle N makes `pend_n_o` 1 from cycle N+1. The cycle-N read is unaffected.
- Reads have no latency and no handshake; outputs settle combinationally from the address and enable inputs.

## Configuration
- Macro `REGFILE_BYPASS_EN`.
- Defined:
  - Bypass hit = `we_i` & `re_n` & (`raddr_n`==`waddr_i`) & (`waddr_i`≠0).
  - On a hit, `rdata_n_o`=`wdata_i` and `pend_n_o`=0.
- Undefined:
  - No bypass path; the read returns the stored array value.
  - `pend_n_o` reflects `pend[raddr_n]` until the clearing edge.
  - Decode must stall one extra cycle on write-back/read collisions.

## Test plan
- Reset: hold `rst`=0 with random inputs → all outputs 0. Release, then read r1..r31 → all 0.
- Write/read: write r5=0x1234_5678, then the next cycle read port 1 r5 and port 2 r0 → `rdata1_o`=0x1234_5678, `rdata2_o`=0. A write to r0 of 0xFFFF_FFFF leaves r0 reading 0.
- Collision: same cycle `we_i`=1, r7=0xA5A5_A5A5, and port 2 reads r7, old r7=0.
  - With `REGFILE_BYPASS_EN`: `rdata2_o`=0xA5A5_A5A5.
  - Without it: `rdata2_o`=0 in that cycle, then 0xA5A5_A5A5 the next cycle.
- Scoreboard: `pset_i` r9 at cycle 0 → `pend1_o`=1 reading r9 at cycle 1 and `any_pend_o`=1. Write-back r9 at cycle 3 → `pend1_o`=0 from cycle 4 (cycle 3 with bypass) and `any_pend_o`=0.
- Set/clear race: r9 pending, same edge `pset_i` r9 and `we_i` r9 → r9 remains pending and its data is updated.
- Async reset mid-stream: with r3 pending and r3=0x55, pulse `rst`=0 between edges → `pend`, array and outputs clear immediately, with no edge required.
